ex_div_unit: RTL and testbench
==============================

EX_DIV_UNIT -- requirements
Module: ex_div_unit

Interface
REQ-001 SHALL have no parameters; operand width fixed at 64 bits (RV64M).
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 valid_in  input  1  ID/EX stage output holds a live instruction.
REQ-006 div_op  input  1  quotient requested (DIV/DIVU/DIVW/DIVUW).
REQ-007 rem_op  input  1  remainder requested (REM/REMU/REMW/REMUW); never high together with div_op.
REQ-008 is_unsign  input  1  unsigned operation.
REQ-009 is_word  input  1  32-bit word operation.
REQ-010 data1  input  64  dividend.
REQ-011 data2  input  64  divisor.
REQ-012 rd_in  input  5  destination register.
REQ-013 kill  input  1  flush from branch/jump or trap; aborts the operation.
REQ-014 stall  output  1  holds the ID/EX stage register and upstream while the unit is busy.
REQ-015 done  output  1  one-cycle pulse; result and rd_out are valid.
REQ-016 result  output  64  quotient or remainder.
REQ-017 rd_out  output  5  destination register latched at start.

Function
REQ-018 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-019 Start condition: state IDLE, valid_in=1, (div_op|rem_op)=1, kill=0.
REQ-020 On start, SHALL latch operands, op type, is_unsign, is_word and rd_in.
REQ-021 stall SHALL be combinationally 1 in the start cycle and in every CALC cycle, and 0 in IDLE without start and in DONE.
REQ-022 Word ops SHALL use data1[31:0] and data2[31:0], sign- or zero-extended per is_unsign; the 32-bit result SHALL be sign-extended to 64 bits, including for unsigned word ops.
REQ-023 Signed ops SHALL divide magnitudes and then fix signs: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-024 Divisor zero (at op width): quotient = all ones at op width; remainder = dividend. Go directly to DONE (done one cycle after start).
REQ-025 Signed overflow (dividend = most-negative at op width, divisor = -1): quotient = dividend; remainder = 0. Go directly to DONE.
REQ-026 Otherwise SHALL do radix-2 restoring division, one quotient bit per CALC cycle: N=64 cycles, or 32 when is_word.
REQ-027 SHALL use a 7-bit iteration counter, loaded with N at start and decremented each CALC cycle; CALC→DONE when the counter reaches 1.
REQ-028 Latency: done asserted exactly N+1 cycles after the start cycle (65 for 64-bit ops, 33 for word ops).
REQ-029 DONE SHALL last exactly one cycle, with done=1; result and rd_out SHALL hold their values until the next start. DONE→IDLE always.
REQ-030 A new start SHALL NOT be accepted in the DONE cycle; the earliest next start is the following IDLE cycle.
REQ-031 kill while in CALC SHALL return the unit to IDLE next cycle, with no done pulse and stall=0 in that IDLE cycle.
REQ-032 kill in the start cycle SHALL suppress the start (stall=0).
REQ-033 kill in the DONE cycle SHALL have no effect; done still pulses.
REQ-034 Non-divide ops (div_op=rem_op=0) SHALL be ignored in all states.

Reset
REQ-035 On rst=1 at a clock edge: state=IDLE, counter=0, done=0, result=0, rd_out=0, internal operand registers=0.
REQ-036 While rst=1, stall SHALL be 0 regardless of the other inputs.
REQ-037 rst mid-CALC SHALL abandon the operation with no done pulse; the first cycle after rst deasserts SHALL accept a start.

Verification
REQ-038 DIV 100/7 starting at cycle 0 -> stall=1 for cycles 0–64; at cycle 65, done=1, result=14, stall=0.
REQ-039 REMW data1=0xFFFFFFF9 (-7), data2=2 -> at cycle 33, done=1, result=0xFFFF_FFFF_FFFF_FFFF.
REQ-040 DIVU 5/0 -> at cycle 1, done=1, result=0xFFFF_FFFF_FFFF_FFFF; REM 5/0 -> result=5.
REQ-041 DIV 0x8000_0000_0000_0000 / -1 -> at cycle 1, result=0x8000_0000_0000_0000; REM with the same operands -> result=0.
REQ-042 DIVUW 0xFFFFFFFF/1 -> at cycle 33, result=0xFFFF_FFFF_FFFF_FFFF (sign-extended).
REQ-043 kill at cycle 10 of CALC -> IDLE at cycle 11, stall=0, no done; a DIV 9/3 started at cycle 12 -> result=3 at cycle 77. Repeat the same sequence with rst instead of kill: same outcome.

Source files
------------

// File: rtl/ex_div_if.sv
// Handshake and data bundle between the ID/EX stage and the iterative divide unit.
interface ex_div_if;
    logic        valid_in;
    logic        div_op;
    logic        rem_op;
    logic        is_unsign;
    logic        is_word;
    logic [63:0] data1;
    logic [63:0] data2;
    logic [4:0]  rd_in;
    logic        kill;
    logic        stall;
    logic        done;
    logic [63:0] result;
    logic [4:0]  rd_out;

    modport master (
        output valid_in, div_op, rem_op, is_unsign, is_word,
        output data1, data2, rd_in, kill,
        input  stall, done, result, rd_out
    );

    modport slave (
        input  valid_in, div_op, rem_op, is_unsign, is_word,
        input  data1, data2, rd_in, kill,
        output stall, done, result, rd_out
    );
endinterface

// File: rtl/ex_div_unit.sv
// RV64M divide/remainder unit: radix-2 restoring division, one quotient bit per cycle,
// with divide-by-zero and signed-overflow results produced directly at start.
module ex_div_unit (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic        start;
    logic [6:0]  cnt;

    // Operand stage registers, captured in the start cycle
    logic        div_sel_p1;
    logic        word_p1;
    logic        q_neg_p1;
    logic        r_neg_p1;
    logic [63:0] dvsr_p1;
    logic [63:0] quo_p1;
    logic [63:0] rem_p1;
    logic [63:0] result_p1;
    logic [4:0]  rd_p1;

    logic [63:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_res;
    logic        a_neg, b_neg, div_zero, ovf;
    logic [64:0] rem_sh;
    logic [63:0] diff, rem_nxt, quo_nxt, fin_val, fin_res;
    logic        ge;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        logic signed [31:0] s;
        s = v;
        return 64'(s);
    endfunction

    function automatic logic [63:0] neg_if(input logic neg, input logic [63:0] v);
        return neg ? (64'd0 - v) : v;
    endfunction

    // Operand conditioning for the start cycle
    always_comb begin
        a_ext = bus.is_word ? (bus.is_unsign ? {32'd0, bus.data1[31:0]} : sext32(bus.data1[31:0]))
                            : bus.data1;
        b_ext = bus.is_word ? (bus.is_unsign ? {32'd0, bus.data2[31:0]} : sext32(bus.data2[31:0]))
                            : bus.data2;
        a_neg    = !bus.is_unsign && a_ext[63];
        b_neg    = !bus.is_unsign && b_ext[63];
        a_mag    = neg_if(a_neg, a_ext);
        b_mag    = neg_if(b_neg, b_ext);
        min_val  = bus.is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div_zero = (b_ext == 64'd0);
        ovf      = !bus.is_unsign && (a_ext == min_val) && (b_ext == {64{1'b1}});
        spec_res = 64'd0;
        if (div_zero)
            spec_res = bus.div_op ? {64{1'b1}} : (bus.is_word ? sext32(bus.data1[31:0]) : bus.data1);
        else if (ovf)
            spec_res = bus.div_op ? a_ext : 64'd0;
    end

    // One restoring step; the 64-bit difference is exact whenever it is kept
    always_comb begin
        rem_sh  = {rem_p1, quo_p1[63]};
        ge      = (rem_sh >= {1'b0, dvsr_p1});
        diff    = rem_sh[63:0] - dvsr_p1;
        rem_nxt = ge ? diff : rem_sh[63:0];
        quo_nxt = {quo_p1[62:0], ge};
        fin_val = div_sel_p1 ? neg_if(q_neg_p1, quo_nxt) : neg_if(r_neg_p1, rem_nxt);
        fin_res = word_p1 ? sext32(fin_val[31:0]) : fin_val;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        unique case (state)
            IDLE: begin
                start = bus.valid_in && (bus.div_op || bus.rem_op) && !bus.kill;
                if (start)
                    state_nxt = (div_zero || ovf) ? DONE : CALC;
            end
            CALC: begin
                if (bus.kill)
                    state_nxt = IDLE;
                else if (cnt == 7'd1)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 7'd0;
            div_sel_p1 <= 1'b0;
            word_p1    <= 1'b0;
            q_neg_p1   <= 1'b0;
            r_neg_p1   <= 1'b0;
            dvsr_p1    <= 64'd0;
            quo_p1     <= 64'd0;
            rem_p1     <= 64'd0;
            result_p1  <= 64'd0;
            rd_p1      <= 5'd0;
        end else if (start) begin
            cnt        <= bus.is_word ? 7'd32 : 7'd64;
            div_sel_p1 <= bus.div_op;
            word_p1    <= bus.is_word;
            q_neg_p1   <= a_neg ^ b_neg;
            r_neg_p1   <= a_neg;
            dvsr_p1    <= b_mag;
            // Word dividends sit in the top half so the same MSB shift-out works
            quo_p1     <= bus.is_word ? {a_mag[31:0], 32'd0} : a_mag;
            rem_p1     <= 64'd0;
            rd_p1      <= bus.rd_in;
            if (div_zero || ovf)
                result_p1 <= spec_res;
        end else if (state == CALC && !bus.kill) begin
            cnt    <= cnt - 7'd1;
            rem_p1 <= rem_nxt;
            quo_p1 <= quo_nxt;
            if (cnt == 7'd1)
                result_p1 <= fin_res;
        end
    end

    assign bus.stall  = !rst && (start || state == CALC);
    assign bus.done   = (state == DONE);
    assign bus.result = result_p1;
    assign bus.rd_out = rd_p1;

endmodule

// File: tb/tb_ex_div_unit.sv
// Randomized and directed bench for ex_div_unit against an arithmetic reference model.
module tb_ex_div_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    ex_div_if dif();

    ex_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_model(input bit dv, input bit uns, input bit wd,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, r32;
        logic [63:0] r64;
        if (wd) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0)
                r32 = dv ? 32'hFFFF_FFFF : a32;
            else if (!uns && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = dv ? a32 : 32'd0;
            else if (uns)
                r32 = dv ? (a32 / b32) : (a32 % b32);
            else if (dv)
                r32 = $signed(a32) / $signed(b32);
            else
                r32 = $signed(a32) % $signed(b32);
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0)
            r64 = dv ? {64{1'b1}} : a;
        else if (!uns && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}})
            r64 = dv ? a : 64'd0;
        else if (uns)
            r64 = dv ? (a / b) : (a % b);
        else if (dv)
            r64 = $signed(a) / $signed(b);
        else
            r64 = $signed(a) % $signed(b);
        return r64;
    endfunction

    function automatic int ref_latency(input bit uns, input bit wd,
                                       input logic [63:0] a, input logic [63:0] b);
        if (wd) begin
            if (b[31:0] == 32'd0) return 1;
            if (!uns && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        if (b == 64'd0) return 1;
        if (!uns && a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) return 1;
        return 65;
    endfunction

    task automatic clear_inputs();
        dif.valid_in  = 1'b0;
        dif.div_op    = 1'b0;
        dif.rem_op    = 1'b0;
        dif.is_unsign = 1'b0;
        dif.is_word   = 1'b0;
        dif.data1     = 64'd0;
        dif.data2     = 64'd0;
        dif.rd_in     = 5'd0;
        dif.kill      = 1'b0;
    endtask

    task automatic drive_op(input bit dv, input bit uns, input bit wd,
                            input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
        dif.valid_in  = 1'b1;
        dif.div_op    = dv;
        dif.rem_op    = !dv;
        dif.is_unsign = uns;
        dif.is_word   = wd;
        dif.data1     = a;
        dif.data2     = b;
        dif.rd_in     = rd;
        dif.kill      = 1'b0;
    endtask

    // Starts one op at the next negedge, follows it to done and checks timing and data.
    task automatic do_op(input string nm, input bit dv, input bit uns, input bit wd,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd,
                         input bit poke_done);
        logic [63:0] exp;
        int lat, cyc, bad;
        exp = ref_model(dv, uns, wd, a, b);
        lat = ref_latency(uns, wd, a, b);
        @(negedge clk);
        drive_op(dv, uns, wd, a, b, rd);
        #1;
        chk({nm, "_start_stall"}, 64'(dif.stall), 64'd1);
        @(posedge clk);
        #1;
        clear_inputs();
        cyc = 0;
        bad = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (dif.done) break;
            if (!dif.stall) bad++;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'(lat));
        chk({nm, "_result"}, dif.result, exp);
        chk({nm, "_rd_out"}, 64'(dif.rd_out), 64'(rd));
        chk({nm, "_busy_stall"}, 64'(bad), 64'd0);
        chk({nm, "_done_stall"}, 64'(dif.stall), 64'd0);
        if (poke_done) begin
            // A request in the DONE cycle must be refused, with or without kill
            drive_op(1'b1, 1'b0, 1'b0, 64'd50, 64'd5, 5'd1);
            dif.kill = 1'($urandom_range(0, 1));
            #1;
            chk({nm, "_done_refuse_stall"}, 64'(dif.stall), 64'd0);
            @(posedge clk);
            #1;
            clear_inputs();
        end
        @(negedge clk);
        chk({nm, "_done_pulse"}, 64'(dif.done), 64'd0);
        chk({nm, "_idle_stall"}, 64'(dif.stall), 64'd0);
        chk({nm, "_hold"}, dif.result, exp);
    endtask

    // Abort an op in CALC cycle 10 by kill or reset, then run DIV 9/3 from cycle 12.
    task automatic abort_seq(input string nm, input bit use_rst);
        @(negedge clk);
        drive_op(1'b1, 1'b0, 1'b0, 64'd1000, 64'd3, 5'd9);
        @(posedge clk);
        #1;
        clear_inputs();
        repeat (9) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else dif.kill = 1'b1;
        @(negedge clk);
        chk({nm, "_c10_stall"}, 64'(dif.stall), use_rst ? 64'd0 : 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        dif.kill = 1'b0;
        @(negedge clk);
        chk({nm, "_c11_stall"}, 64'(dif.stall), 64'd0);
        chk({nm, "_c11_done"}, 64'(dif.done), 64'd0);
        if (use_rst) chk({nm, "_c11_result"}, dif.result, 64'd0);
        do_op({nm, "_div9_3"}, 1'b1, 1'b0, 1'b0, 64'd9, 64'd3, 5'd4, 1'b0);
    endtask

    function automatic logic [63:0] pick(input int sel);
        case (sel)
            0: return 64'd0;
            1: return {64{1'b1}};
            2: return 64'h8000_0000_0000_0000;
            3: return 64'(32'h8000_0000);
            4: return 64'($urandom_range(1, 20));
            5: return {32'd0, 32'($urandom)};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        clear_inputs();
        drive_op(1'b1, 1'b0, 1'b0, 64'd100, 64'd7, 5'd3);
        #1;
        chk("rst_stall_pre", 64'(dif.stall), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 64'(dif.stall), 64'd0);
        chk("rst_done", 64'(dif.done), 64'd0);
        chk("rst_result", dif.result, 64'd0);
        chk("rst_rd_out", 64'(dif.rd_out), 64'd0);
        clear_inputs();
        rst = 1'b0;

        do_op("div_100_7",   1'b1, 1'b0, 1'b0, 64'd100, 64'd7, 5'd5, 1'b0);
        do_op("remw_m7_2",   1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd6, 1'b0);
        do_op("divu_5_0",    1'b1, 1'b1, 1'b0, 64'd5, 64'd0, 5'd7, 1'b0);
        do_op("rem_5_0",     1'b0, 1'b0, 1'b0, 64'd5, 64'd0, 5'd8, 1'b0);
        do_op("div_ovf",     1'b1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd10, 1'b0);
        do_op("rem_ovf",     1'b0, 1'b0, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 5'd11, 1'b0);
        do_op("divuw_ff_1",  1'b1, 1'b1, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd12, 1'b0);
        do_op("divw_ovf",    1'b1, 1'b0, 1'b1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd13, 1'b1);
        do_op("remuw_zero",  1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_0001, 64'hABCD_0000_0000_0000, 5'd14, 1'b1);
        do_op("div_neg",     1'b1, 1'b0, 1'b0, -64'sd1000, 64'd7, 5'd15, 1'b1);

        abort_seq("kill", 1'b0);
        abort_seq("rst", 1'b1);

        // Non-divide requests must be ignored
        @(negedge clk);
        dif.valid_in = 1'b1;
        dif.data1    = 64'd10;
        dif.data2    = 64'd2;
        #1;
        chk("nondiv_stall", 64'(dif.stall), 64'd0);
        @(negedge clk);
        chk("nondiv_stall2", 64'(dif.stall), 64'd0);
        chk("nondiv_done", 64'(dif.done), 64'd0);
        clear_inputs();

        for (int i = 0; i < 40; i++) begin
            logic [63:0] a, b;
            a = pick(int'($urandom_range(0, 8)));
            b = pick(int'($urandom_range(0, 8)));
            do_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), a, b, 5'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
